mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters:
//  the CPU's controller-driven port (fetch/load/store) and a debug/loader port.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin CPU/debug arbiter for a single unified memory with
//            variable-latency handshake and per-access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_ready,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_adr,
    input  logic [DW-1:0] dbg_wd,
    output logic [DW-1:0] dbg_rd,
    output logic          dbg_ready,
    output logic          dbg_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    input  logic          mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_resp   = 2'd2;

    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_dbg;
    logic          r_owner_dbg;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_adr;
    logic [DW-1:0] r_mem_wd;
    logic [DW-1:0] r_cpu_rd;
    logic [DW-1:0] r_dbg_rd;
    logic          r_cpu_ready;
    logic          r_cpu_err;
    logic          r_dbg_ready;
    logic          r_dbg_err;

    logic          w_pick_dbg;
    logic          w_done;
    logic          w_timeout;
    logic [DW-1:0] w_resp_rd;

    // Debug wins only when it is alone or the CPU had the previous grant.
    assign w_pick_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
    assign w_timeout  = ~mem_ack & (r_cnt == c_cnt_last);
    assign w_done     = mem_ack | w_timeout;
    assign w_resp_rd  = (mem_ack & ~r_mem_we) ? mem_rd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_cnt       <= '0;
            r_last_dbg  <= 1'b1;
            r_owner_dbg <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wd    <= '0;
            r_cpu_rd    <= '0;
            r_dbg_rd    <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dbg_ready <= 1'b0;
            r_dbg_err   <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dbg_ready <= 1'b0;
            r_dbg_err   <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_cnt <= '0;
                    if (cpu_req | dbg_req) begin
                        r_owner_dbg <= w_pick_dbg;
                        r_last_dbg  <= w_pick_dbg;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_pick_dbg ? dbg_we  : cpu_we;
                        r_mem_adr   <= w_pick_dbg ? dbg_adr : cpu_adr;
                        r_mem_wd    <= w_pick_dbg ? dbg_wd  : cpu_wd;
                        r_state     <= c_access;
                    end
                end
                c_access: begin
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= c_resp;
                        if (r_owner_dbg) begin
                            r_dbg_ready <= 1'b1;
                            r_dbg_err   <= w_timeout;
                            r_dbg_rd    <= w_resp_rd;
                        end else begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_err   <= w_timeout;
                            r_cpu_rd    <= w_resp_rd;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_resp: begin
                    r_cnt   <= '0;
                    r_state <= c_idle;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= c_idle;
                end
            endcase
        end
    end

    assign cpu_rd    = r_cpu_rd;
    assign cpu_ready = r_cpu_ready;
    assign cpu_err   = r_cpu_err;
    assign dbg_rd    = r_dbg_rd;
    assign dbg_ready = r_dbg_ready;
    assign dbg_err   = r_dbg_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_adr   = r_mem_adr;
    assign mem_wd    = r_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_adr, dbg_adr;
    logic [DW-1:0] cpu_wd, dbg_wd, cpu_rd, dbg_rd;
    logic          cpu_ready, cpu_err, dbg_ready, dbg_err;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd, mem_rd;

    int n_checks;
    int n_fail;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_adr   (dbg_adr),
        .dbg_wd    (dbg_wd),
        .dbg_rd    (dbg_rd),
        .dbg_ready (dbg_ready),
        .dbg_err   (dbg_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int owner;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
        dbg_req = 0; dbg_we = 0; dbg_adr = '0; dbg_wd = '0;
        mem_rd = '0; mem_ack = 0;
        step();
        step();
        check_eq("rst_mem_req",   mem_req,   0);
        check_eq("rst_cpu_ready", cpu_ready, 0);
        check_eq("rst_dbg_ready", dbg_ready, 0);
        check_eq("rst_mem_adr",   mem_adr,   0);
        check_eq("rst_cpu_rd",    cpu_rd,    0);
        reset = 1'b0;

        // 1: CPU read, zero wait
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h100;
        step();
        check_eq("t1_mem_req", mem_req, 1);
        check_eq("t1_mem_adr", mem_adr, 32'h100);
        check_eq("t1_mem_we",  mem_we,  0);
        cpu_req = 0;
        mem_ack = 1; mem_rd = 32'hDEADBEEF;
        step();
        mem_ack = 0;
        check_eq("t1_cpu_ready", cpu_ready, 1);
        check_eq("t1_cpu_rd",    cpu_rd,    32'hDEADBEEF);
        check_eq("t1_cpu_err",   cpu_err,   0);
        check_eq("t1_dbg_ready", dbg_ready, 0);
        check_eq("t1_mem_req_off", mem_req, 0);
        step();
        check_eq("t1_ready_pulse", cpu_ready, 0);

        // 2: debug write, 3 wait states
        dbg_req = 1; dbg_we = 1; dbg_adr = 32'h40; dbg_wd = 32'h12345678;
        mem_rd = 32'hFFFF0000;
        step();
        for (int c = 1; c <= 4; c++) begin
            check_eq("t2_mem_req", mem_req, 1);
            check_eq("t2_cpu_ready", cpu_ready, 0);
            if (c == 4) mem_ack = 1;
            step();
        end
        mem_ack = 0;
        check_eq("t2_mem_we", mem_we, 1);
        check_eq("t2_mem_wd", mem_wd, 32'h12345678);
        check_eq("t2_mem_adr", mem_adr, 32'h40);
        check_eq("t2_dbg_ready", dbg_ready, 1);
        check_eq("t2_dbg_rd", dbg_rd, 0);
        check_eq("t2_cpu_ready", cpu_ready, 0);
        dbg_req = 0; dbg_we = 0;
        step();

        // 3: simultaneous requests after reset -> CPU, DBG, CPU, DBG
        reset = 1; step(); reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'hC00;
        dbg_req = 1; dbg_we = 0; dbg_adr = 32'hD00;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (mem_req !== 1'b1 && n < 10) begin
                check_eq("t3_no_dual_ready", cpu_ready & dbg_ready, 0);
                step();
                n++;
            end
            check_eq("t3_grant_wait", (n < 10), 1);
            owner = (mem_adr == 32'hD00) ? 1 : 0;
            check_eq("t3_grant_order", owner, i % 2);
            mem_ack = 1; mem_rd = 32'hA0 + i;
            if (i == 3) begin
                cpu_req = 0; dbg_req = 0;
            end
            step();
            mem_ack = 0;
            check_eq("t3_cpu_ready", cpu_ready, (i % 2 == 0));
            check_eq("t3_dbg_ready", dbg_ready, (i % 2 == 1));
            check_eq("t3_rd", (i % 2 == 0) ? cpu_rd : dbg_rd, 32'hA0 + i);
            step();
        end
        step();
        check_eq("t3_idle_after", mem_req, 0);

        // 4: timeout, then a late ack is ignored
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h200;
        step();
        cpu_req = 0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            check_eq("t4_no_early_ready", cpu_ready, 0);
            step();
            n++;
        end
        check_eq("t4_access_cycles", n, 15);
        check_eq("t4_cpu_ready", cpu_ready, 1);
        check_eq("t4_cpu_err", cpu_err, 1);
        check_eq("t4_cpu_rd", cpu_rd, 0);
        step();
        mem_ack = 1; mem_rd = 32'h55555555;
        step();
        mem_ack = 0;
        check_eq("t4_late_ack_ready", cpu_ready, 0);
        check_eq("t4_late_ack_mem_req", mem_req, 0);
        step();
        check_eq("t4_late_ack_ready2", cpu_ready | dbg_ready, 0);

        // 5: reset mid-access, then CPU wins the tie
        dbg_req = 1; dbg_we = 0; dbg_adr = 32'h300;
        step();
        check_eq("t5_mem_req", mem_req, 1);
        step();
        reset = 1;
        step();
        check_eq("t5_rst_mem_req", mem_req, 0);
        check_eq("t5_rst_dbg_ready", dbg_ready, 0);
        check_eq("t5_rst_cpu_ready", cpu_ready, 0);
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h310;
        step();
        check_eq("t5_no_ready_after", dbg_ready | cpu_ready, 0);
        check_eq("t5_tie_cpu", mem_adr, 32'h310);
        mem_ack = 1; mem_rd = 32'h0BADF00D;
        cpu_req = 0; dbg_req = 0;
        step();
        mem_ack = 0;
        check_eq("t5_cpu_ready", cpu_ready, 1);
        check_eq("t5_dbg_ready", dbg_ready, 0);
        step();

        // 6: address change during wait states does not reach memory
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10;
        step();
        check_eq("t6_adr_c1", mem_adr, 32'h10);
        cpu_adr = 32'h20; cpu_wd = 32'h99;
        step();
        check_eq("t6_adr_c2", mem_adr, 32'h10);
        step();
        check_eq("t6_adr_c3", mem_adr, 32'h10);
        check_eq("t6_wd_c3", mem_wd, 0);
        mem_ack = 1; mem_rd = 32'h600D;
        cpu_req = 0;
        step();
        mem_ack = 0;
        check_eq("t6_cpu_ready", cpu_ready, 1);
        check_eq("t6_cpu_rd", cpu_rd, 32'h600D);
        check_eq("t6_adr_resp", mem_adr, 32'h10);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
